jtag_tap_target: RTL

- Target-side (responder) JTAG TAP, the device end of the link that the JTAG controller agent drives with TMS/TDI.
- Implements the 16-state IEEE 1149.1 TAP FSM, an instruction register and three data registers: bypass, user-defined and boundary-scan.
- Shifts TDI in and presents TDO so the controller and its monitor can check scanned-out data.
- Used as the DUT/slave model in the JTAG AVIP HDL top.

---
 rtl/jtag_tap_target.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/jtag_tap_target.sv
// Target-side JTAG TAP: 16-state 1149.1 controller with an instruction
// register and bypass, user-defined and boundary-scan data registers.
module jtag_tap_target #(
    parameter int unsigned IR_WIDTH      = 5,
    parameter int unsigned USER_DR_WIDTH = 32,
    parameter int unsigned BSR_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tms,
    input  logic                     tdi,
    output logic                     tdo,
    output logic                     tdo_en,
    output logic [3:0]               tap_state,
    output logic [IR_WIDTH-1:0]      ir_out,
    input  logic [USER_DR_WIDTH-1:0] user_capture,
    input  logic [BSR_WIDTH-1:0]     bsr_capture,
    output logic [USER_DR_WIDTH-1:0] user_dr_out,
    output logic [BSR_WIDTH-1:0]     bsr_out,
    output logic                     update_pulse
);

    localparam logic [3:0] ST_RESET      = 4'd0;
    localparam logic [3:0] ST_IDLE       = 4'd1;
    localparam logic [3:0] ST_DR_SCAN    = 4'd2;
    localparam logic [3:0] ST_IR_SCAN    = 4'd3;
    localparam logic [3:0] ST_CAPTURE_IR = 4'd4;
    localparam logic [3:0] ST_SHIFT_IR   = 4'd5;
    localparam logic [3:0] ST_EXIT1_IR   = 4'd6;
    localparam logic [3:0] ST_PAUSE_IR   = 4'd7;
    localparam logic [3:0] ST_EXIT2_IR   = 4'd8;
    localparam logic [3:0] ST_UPDATE_IR  = 4'd9;
    localparam logic [3:0] ST_CAPTURE_DR = 4'd10;
    localparam logic [3:0] ST_SHIFT_DR   = 4'd11;
    localparam logic [3:0] ST_EXIT1_DR   = 4'd12;
    localparam logic [3:0] ST_PAUSE_DR   = 4'd13;
    localparam logic [3:0] ST_EXIT2_DR   = 4'd14;
    localparam logic [3:0] ST_UPDATE_DR  = 4'd15;

    localparam logic [IR_WIDTH-1:0] OP_USER    = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] OP_BSR     = IR_WIDTH'(6);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

    logic [3:0]               state;
    logic [3:0]               next_state;
    logic [IR_WIDTH-1:0]      ir_sr;
    logic                     bypass_sr;
    logic [USER_DR_WIDTH-1:0] user_sr;
    logic [BSR_WIDTH-1:0]     bsr_sr;
    logic                     sel_user;
    logic                     sel_bsr;

    assign tap_state = state;
    assign sel_user  = (ir_out == OP_USER);
    assign sel_bsr   = (ir_out == OP_BSR);

    // TAP state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_RESET;
        else       state <= next_state;
    end

    // TAP next-state decode on tms
    always_comb begin
        next_state = state;
        case (state)
            ST_RESET:      next_state = tms ? ST_RESET    : ST_IDLE;
            ST_IDLE:       next_state = tms ? ST_DR_SCAN  : ST_IDLE;
            ST_DR_SCAN:    next_state = tms ? ST_IR_SCAN  : ST_CAPTURE_DR;
            ST_IR_SCAN:    next_state = tms ? ST_RESET    : ST_CAPTURE_IR;
            ST_CAPTURE_IR: next_state = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR:   next_state = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR:   next_state = tms ? ST_UPDATE_IR : ST_PAUSE_IR;
            ST_PAUSE_IR:   next_state = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR:   next_state = tms ? ST_UPDATE_IR : ST_SHIFT_IR;
            ST_UPDATE_IR:  next_state = tms ? ST_DR_SCAN  : ST_IDLE;
            ST_CAPTURE_DR: next_state = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR:   next_state = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR:   next_state = tms ? ST_UPDATE_DR : ST_PAUSE_DR;
            ST_PAUSE_DR:   next_state = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR:   next_state = tms ? ST_UPDATE_DR : ST_SHIFT_DR;
            ST_UPDATE_DR:  next_state = tms ? ST_DR_SCAN  : ST_IDLE;
            default:       next_state = ST_RESET;
        endcase
    end

    // Instruction shift register and latched instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_sr  <= '0;
            ir_out <= '0;
        end else begin
            case (state)
                ST_CAPTURE_IR: ir_sr  <= IR_CAPTURE;
                ST_SHIFT_IR:   ir_sr  <= {tdi, ir_sr[IR_WIDTH-1:1]};
                ST_UPDATE_IR:  ir_out <= ir_sr;
                default: ;
            endcase
            // Test-Logic-Reset reached through tms falls back to bypass
            if (next_state == ST_RESET) ir_out <= '0;
        end
    end

    // Data registers: capture, shift and update of the selected register
    always_ff @(posedge clk) begin
        if (reset) begin
            bypass_sr    <= 1'b0;
            user_sr      <= '0;
            bsr_sr       <= '0;
            user_dr_out  <= '0;
            bsr_out      <= '0;
            update_pulse <= 1'b0;
        end else begin
            update_pulse <= 1'b0;
            case (state)
                ST_CAPTURE_DR: begin
                    if (sel_user)     user_sr   <= user_capture;
                    else if (sel_bsr) bsr_sr    <= bsr_capture;
                    else              bypass_sr <= 1'b0;
                end
                ST_SHIFT_DR: begin
                    if (sel_user)     user_sr   <= {tdi, user_sr[USER_DR_WIDTH-1:1]};
                    else if (sel_bsr) bsr_sr    <= {tdi, bsr_sr[BSR_WIDTH-1:1]};
                    else              bypass_sr <= tdi;
                end
                ST_UPDATE_DR: begin
                    if (sel_user) begin
                        user_dr_out  <= user_sr;
                        update_pulse <= 1'b1;
                    end else if (sel_bsr) begin
                        bsr_out      <= bsr_sr;
                        update_pulse <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Serial output: LSB of the register being shifted
    always_comb begin
        tdo    = 1'b0;
        tdo_en = 1'b0;
        if (state == ST_SHIFT_IR) begin
            tdo    = ir_sr[0];
            tdo_en = 1'b1;
        end else if (state == ST_SHIFT_DR) begin
            tdo_en = 1'b1;
            if (sel_user)     tdo = user_sr[0];
            else if (sel_bsr) tdo = bsr_sr[0];
            else              tdo = bypass_sr;
        end
    end

endmodule
